// File: rtl/rsa_encrypt.sv
// rsa_encrypt: c = m^e mod n, right-to-left square-and-multiply on bit-serial interleaved multipliers.
// Optional RSA_ENCRYPT_EARLY_EXIT_EN: stop once the remaining exponent bits are all zero (leaks length of e).
module rsa_encrypt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, EXP, FIN} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_m, r_e, r_n, r_result, r_base;
  logic [WIDTH-1:0] r_acc_r, r_acc_b;
  logic [KW-1:0]    r_k, r_j;
  logic [WIDTH-1:0] w_acc_r, w_acc_b, w_result_upd;
  logic             w_bad, w_last_iter, w_e_zero;

  // Accumulators are always < n, so only the step itself needs the extra carry bit.
  function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] acc,
                                               input logic             bit_a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] mod);
    logic [WIDTH:0] t, nn;
    nn = {1'b0, mod};
    t  = {acc, 1'b0};
    if (t >= nn) t = t - nn;
    if (bit_a) begin
      t = t + {1'b0, b};
      if (t >= nn) t = t - nn;
    end
    return t[WIDTH-1:0];
  endfunction

  assign w_acc_r      = mm_step(r_acc_r, r_result[r_j], r_base, r_n);
  assign w_acc_b      = mm_step(r_acc_b, r_base[r_j], r_base, r_n);
  assign w_result_upd = r_e[r_k] ? w_acc_r : r_result;
  assign w_bad        = (r_n == '0) || (r_m >= r_n);
  assign w_e_zero     = (r_e == '0);

`ifdef RSA_ENCRYPT_EARLY_EXIT_EN
  assign w_last_iter = (r_k == KW'(WIDTH - 1)) || (((r_e >> r_k) >> 1) == '0);
`else
  assign w_last_iter = (r_k == KW'(WIDTH - 1));
`endif

  assign busy = (r_state == CHECK) || (r_state == EXP);
  assign done = (r_state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = CHECK;
      CHECK: begin
        if (w_bad) w_next = FIN;
`ifdef RSA_ENCRYPT_EARLY_EXIT_EN
        else if (w_e_zero) w_next = FIN;
`endif
        else w_next = EXP;
      end
      EXP:   if (r_j == '0 && w_last_iter) w_next = FIN;
      FIN:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m      <= '0;
      r_e      <= '0;
      r_n      <= '0;
      r_result <= '0;
      r_base   <= '0;
      r_acc_r  <= '0;
      r_acc_b  <= '0;
      r_k      <= '0;
      r_j      <= '0;
      c        <= '0;
      err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_m <= m;
          r_e <= e;
          r_n <= n;
          err <= 1'b0;
          c   <= '0;
        end
        CHECK: begin
          if (w_bad) begin
            err <= 1'b1;
            c   <= '0;
          end else begin
            r_result <= (r_n == WIDTH'(1)) ? '0 : WIDTH'(1);
            r_base   <= r_m;
            r_k      <= '0;
            r_j      <= KW'(WIDTH - 1);
            r_acc_r  <= '0;
            r_acc_b  <= '0;
`ifdef RSA_ENCRYPT_EARLY_EXIT_EN
            if (w_e_zero) c <= (r_n == WIDTH'(1)) ? '0 : WIDTH'(1);
`endif
          end
        end
        EXP: begin
          if (r_j == '0) begin
            r_base   <= w_acc_b;
            r_result <= w_result_upd;
            r_k      <= r_k + KW'(1);
            r_j      <= KW'(WIDTH - 1);
            r_acc_r  <= '0;
            r_acc_b  <= '0;
            if (w_last_iter) c <= w_result_upd;
          end else begin
            r_acc_r <= w_acc_r;
            r_acc_b <= w_acc_b;
            r_j     <= r_j - KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_encrypt.sv
// Self-checking bench for rsa_encrypt: directed vector table, handshake/reset sequences, random ops vs a modexp model.
module tb_rsa_encrypt;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] m = '0, e = '0, n = '0;
  logic [W-1:0] c;
  logic         busy, done, err;

  int checks = 0;
  int failures = 0;

  rsa_encrypt #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m(m), .e(e), .n(n),
    .c(c), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] m, e, n, c;
    logic         err;
  } vec_t;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_c(input logic [W-1:0] am, ae, an, output logic oerr);
    longint unsigned r, b, nn;
    oerr = 1'b0;
    if (an == 0 || am >= an) begin
      oerr = 1'b1;
      return '0;
    end
    nn = longint'(an);
    r  = 1 % nn;
    b  = longint'(am);
    for (int i = 0; i < W; i++) begin
      if (ae[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[W-1:0];
  endfunction

  function automatic int model_lat(input logic [W-1:0] am, ae, an);
    int top;
    if (an == 0 || am >= an) return 2;
`ifdef RSA_ENCRYPT_EARLY_EXIT_EN
    if (ae == 0) return 2;
    top = 0;
    for (int i = 0; i < W; i++) if (ae[i]) top = i;
    return 2 + (top + 1) * W;
`else
    top = 0;
    return 2 + top + W * W;
`endif
  endfunction

  // Latency counts rising edges, the start-sampling edge being number 1.
  task automatic run_op(input logic [W-1:0] am, ae, an, input int inject_at,
                        output logic [W-1:0] oc, output logic oerr,
                        output int olat, output int ndone, output logic busy_ok);
    int   cnt;
    logic seen;
    oc = '0; oerr = 1'b0; olat = -1; ndone = 0; busy_ok = 1'b1; seen = 1'b0;
    @(negedge clk);
    m = am; e = ae; n = an; start = 1'b1;
    @(posedge clk);
    cnt = 1;
    #1 start = 1'b0;
    if (!busy || done) busy_ok = 1'b0;
    while (!seen && cnt < 3000) begin
      @(posedge clk);
      cnt++;
      #1;
      if (start) start = 1'b0;
      if (cnt == inject_at) begin
        start = 1'b1;
        m = 32'd123; e = 32'd3; n = 32'd9999;
      end
      if (done) begin
        seen = 1'b1; ndone++; olat = cnt; oc = c; oerr = err;
        if (busy) busy_ok = 1'b0;
      end else if (!busy) busy_ok = 1'b0;
    end
    if (!seen) chk("timeout", 0, 1);
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (busy) busy_ok = 1'b0;
    end
  endtask

  vec_t         vt[12];
  logic [W-1:0] rc, xc, rm, re, rn, hold_c;
  logic         rerr, xerr, bok;
  int           lat, nd, ndone_rst;

  initial begin
    vt[0]  = '{m:32'd65,   e:32'd17,   n:32'd3233, c:32'd2790, err:1'b0};
    vt[1]  = '{m:32'd2790, e:32'd2753, n:32'd3233, c:32'd65,   err:1'b0};
    vt[2]  = '{m:32'd123,  e:32'd17,   n:32'd3233, c:32'd855,  err:1'b0};
    vt[3]  = '{m:32'd5,    e:32'd3,    n:32'd0,    c:32'd0,    err:1'b1};
    vt[4]  = '{m:32'd3233, e:32'd17,   n:32'd3233, c:32'd0,    err:1'b1};
    vt[5]  = '{m:32'd65,   e:32'd17,   n:32'd3233, c:32'd2790, err:1'b0};
    vt[6]  = '{m:32'd5,    e:32'd0,    n:32'd7,    c:32'd1,    err:1'b0};
    vt[7]  = '{m:32'd0,    e:32'd5,    n:32'd7,    c:32'd0,    err:1'b0};
    vt[8]  = '{m:32'd0,    e:32'd3,    n:32'd1,    c:32'd0,    err:1'b0};
    vt[9]  = '{m:32'd6,    e:32'd2,    n:32'd7,    c:32'd1,    err:1'b0};
    vt[10] = '{m:32'd10,   e:32'd0,    n:32'd1,    c:32'd0,    err:1'b1};
    vt[11] = '{m:32'd3,    e:32'd4,    n:32'd10,   c:32'd1,    err:1'b0};

    #2;
    chk("reset_c", c, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].m, vt[i].e, vt[i].n, 0, rc, rerr, lat, nd, bok);
      chk($sformatf("vec%0d_c", i), rc, vt[i].c);
      chk($sformatf("vec%0d_err", i), rerr, vt[i].err);
      chk($sformatf("vec%0d_lat", i), lat, model_lat(vt[i].m, vt[i].e, vt[i].n));
      chk($sformatf("vec%0d_ndone", i), nd, 1);
      chk($sformatf("vec%0d_busy", i), bok, 1);
      if (i == 4) chk("err_held", err, 1);
      if (i == 2) chk("c_held", c, 855);
    end

    // Second start at cycle 10 with other operands must be ignored.
    run_op(32'd65, 32'd17, 32'd3233, 10, rc, rerr, lat, nd, bok);
    chk("hs_c", rc, 2790);
    chk("hs_lat", lat, model_lat(32'd65, 32'd17, 32'd3233));
    chk("hs_ndone", nd, 1);
    chk("hs_busy", bok, 1);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    m = 32'd65; e = 32'd17; n = 32'd3233; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (499) @(posedge clk);
    #1 chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_c", c, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    ndone_rst = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done) ndone_rst++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 if (done) ndone_rst++;
    end
    chk("rst_no_done", ndone_rst, 0);
    run_op(32'd123, 32'd17, 32'd3233, 0, rc, rerr, lat, nd, bok);
    chk("post_rst_c", rc, 855);
    chk("post_rst_lat", lat, model_lat(32'd123, 32'd17, 32'd3233));

    // Random operands, modulus top bit often set to exercise the carry bit.
    for (int i = 0; i < 6; i++) begin
      rn = $urandom;
      if (i % 2 == 0) rn = rn | 32'h8000_0000;
      if (rn == 0) rn = 32'd97;
      rm = $urandom % rn;
      re = (i == 5) ? 32'd3 : $urandom;
      xc = model_c(rm, re, rn, xerr);
      run_op(rm, re, rn, 0, rc, rerr, lat, nd, bok);
      chk($sformatf("rnd%0d_c", i), rc, xc);
      chk($sformatf("rnd%0d_err", i), rerr, xerr);
      chk($sformatf("rnd%0d_lat", i), lat, model_lat(rm, re, rn));
      hold_c = rc;
    end
    repeat (5) @(posedge clk);
    #1 chk("c_hold_idle", c, hold_c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
